// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS multiply/divide unit with private HI/LO.
// MULT/MULTU use a radix-2 shift-add loop and DIV/DIVU use a radix-2
// restoring divider. Both work on operand magnitudes, and a final FIX cycle
// applies the signs. MTHI/MTLO write HI/LO directly while the unit is idle.
// Optional macro MULDIV_FAST_MULT_EN: when defined, MULT/MULTU compute the
// product combinationally at acceptance and go straight to FIX.
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               res_neg;
   logic               rem_neg;
   // Multiply: {accumulator, multiplier}. Divide: {partial remainder, dividend/quotient}.
   logic [2*WIDTH-1:0] work;
   // Multiply: multiplicand magnitude. Divide: divisor magnitude.
   logic [WIDTH-1:0]   operand_b;

   logic               signed_op;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] product_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_product;
`endif

   assign busy = (state != IDLE);

   // Operand magnitudes, per-step datapath and sign fix-up values
   always_comb begin
      signed_op   = (op == OP_MULT) || (op == OP_DIV);
      a_mag       = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      b_mag       = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
      // Shift-add step: conditionally add the multiplicand into the upper half
      mul_sum     = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand_b} : '0);
      // Restoring step: shift in the next dividend bit and trial-subtract; bit WIDTH is the borrow
      div_trial   = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]} - {1'b0, operand_b};
      product_fix = res_neg ? -work : work;
      quot_fix    = res_neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
      rem_fix     = rem_neg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
   end

`ifdef MULDIV_FAST_MULT_EN
   // Single-cycle magnitude product for the fast multiply path
   always_comb begin
      fast_product = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
   end
`endif

   // Control FSM, iteration datapath and HI/LO register updates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         is_div    <= 1'b0;
         res_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         work      <= '0;
         operand_b <= '0;
         done      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi <= rs_data;
                     OP_MTLO: lo <= rs_data;
                     OP_MULT, OP_MULTU: begin
                        is_div    <= 1'b0;
                        res_neg   <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        rem_neg   <= signed_op & rs_data[WIDTH-1];
                        operand_b <= a_mag;
                        count     <= '0;
`ifdef MULDIV_FAST_MULT_EN
                        work      <= fast_product;
                        state     <= FIX;
`else
                        work      <= {{WIDTH{1'b0}}, b_mag};
                        state     <= RUN;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        is_div    <= 1'b1;
                        res_neg   <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        rem_neg   <= signed_op & rs_data[WIDTH-1];
                        operand_b <= b_mag;
                        work      <= {{WIDTH{1'b0}}, a_mag};
                        count     <= '0;
                        state     <= RUN;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               count <= count + 1'b1;
               if (count == LAST_STEP) begin
                  state <= FIX;
               end
               if (is_div) begin
                  if (!div_trial[WIDTH]) begin
                     work <= {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
                  end else begin
                     work <= {work[2*WIDTH-2:0], 1'b0};
                  end
               end else begin
                  work <= {mul_sum, work[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (is_div) begin
                  lo <= quot_fix;
                  hi <= rem_fix;
               end else begin
                  hi <= product_fix[2*WIDTH-1:WIDTH];
                  lo <= product_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed and randomized checks of mips_muldiv_unit
// against a transaction-level reference model (plain 64-bit arithmetic plus
// a latency countdown).
module tb_mips_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   // reference model state
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_done;
   int          m_left;
   logic [63:0] m_pend;

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} computed from the instruction definitions
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        q;
      logic [31:0]        r;
      sa = a;
      sb = b;
      p  = '0;
      case (o)
         3'd0: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         3'd1: p = {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 32'h0) begin
               p = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               p = {32'h0, 32'h80000000};
            end else begin
               q = sa / sb;
               r = sa % sb;
               p = {r, q};
            end
         end
         default: begin
            if (b == 32'h0) p = {a, 32'hFFFFFFFF};
            else            p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Reference model: one update per clock edge, asynchronous reset
   initial begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0; m_pend = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
         end else begin
            m_done = 1'b0;
            if (m_left == 0) begin
               if (start) begin
                  case (op)
                     3'd4: m_hi = rs_data;
                     3'd5: m_lo = rs_data;
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        m_pend = ref_result(op, rs_data, rt_data);
                        m_left = (op < 3'd2) ? MUL_LAT : DIV_LAT;
                     end
                     default: ;
                  endcase
               end
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_hi   = m_pend[63:32];
                  m_lo   = m_pend[31:0];
                  m_done = 1'b1;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison of DUT outputs against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && chk_en) begin
            check("busy", 32'(busy), 32'(m_left != 0));
            check("done", 32'(done), 32'(m_done));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      $display("txn op=%0d rs=%h rt=%h", o, a, b);
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         cycle();
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_lat);
      int n;
      do_op(o, a, b);
      wait_idle(n);
      check({name, "_lat"}, 32'(n), 32'(exp_lat));
      check({name, "_done"}, 32'(done), 32'h1);
      check({name, "_hi"}, hi, exp_hi);
      check({name, "_lo"}, lo, exp_lo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      rst_n   = 1'b1;
      start   = 1'b0;
      op      = 3'd0;
      rs_data = '0;
      rt_data = '0;
      #2 rst_n = 1'b0;
      cycle();
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      cycle();

      // multiply
      run_op("mult", 3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT);
      run_op("multu", 3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MUL_LAT);
      // divide
      run_op("div", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
      run_op("divu", 3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_LAT);
      run_op("divu0", 3'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, DIV_LAT);
      run_op("divneg0", 3'd2, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'h00000001, DIV_LAT);
      run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);

      // MTHI / MTLO on consecutive cycles
      cycle();
      do_op(3'd4, 32'hDEADBEEF, 32'h0);
      check("mthi_hi", hi, 32'hDEADBEEF);
      check("mthi_busy", 32'(busy), 32'h0);
      check("mthi_done", 32'(done), 32'h0);
      do_op(3'd5, 32'hCAFEF00D, 32'h0);
      check("mtlo_lo", lo, 32'hCAFEF00D);
      check("mtlo_hi", hi, 32'hDEADBEEF);
      check("mtlo_busy", 32'(busy), 32'h0);
      check("mtlo_done", 32'(done), 32'h0);

      // MTLO while busy is ignored; back-to-back issue in the done cycle
      do_op(3'd3, 32'd100, 32'd7);
      repeat (3) cycle();
      do_op(3'd5, 32'h11111111, 32'h0);
      wait_idle(n);
      check("ign_done", 32'(done), 32'h1);
      check("ign_lo", lo, 32'd14);
      check("ign_hi", hi, 32'd2);
      run_op("b2b", 3'd1, 32'd5, 32'd7, 32'd0, 32'd35, MUL_LAT);

      // reset in the middle of a multiply
      do_op(3'd1, 32'd5, 32'd7);
      repeat (9) cycle();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_hi", hi, 32'h0);
      check("midrst_lo", lo, 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      cycle();
      cycle();
      rst_n = 1'b1;
      repeat (40) cycle();
      check("postrst_done", 32'(done), 32'h0);
      check("postrst_lo", lo, 32'h0);
      check("postrst_busy", 32'(busy), 32'h0);

      // randomized traffic, including starts while busy and reserved ops
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         op      = 3'($urandom_range(0, 7));
         rs_data = pick();
         rt_data = pick();
         if (start && m_left == 0)
            $display("txn op=%0d rs=%h rt=%h", op, rs_data, rt_data);
         cycle();
      end
      start = 1'b0;
      repeat (40) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with its own HI/LO register pair.
- Sits directly downstream of the instruction decoder and consumes the decoded MULT, MULTU, DIV, DIVU, MTHI and MTLO operations.
- Exposes HI/LO to the datapath for MFHI/MFLO.
- Asserts busy so the pipeline control stalls any HI/LO access or new mul/div issue until the operation completes.

Parameters:
- WIDTH, 32, operand and HI/LO width; the only supported value is 32, and the other figures in this spec assume it.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue strobe; sampled only when busy=0
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (ignored)
- rs_data  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_data  in  32  operand B (divisor / multiplier)
- busy  out  1  high while a mul/div is in flight
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, busy=0, done=0, hi=0, lo=0 and the iteration counter to 0.
  - Applies at any time, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - done is low except in the single cycle following FIX.
  - start=1 with op=4: hi<=rs_data at the same edge. start=1 with op=5: lo<=rs_data. Neither raises busy or done.
  - start=1 with op 0-3: capture operands, set signs, go to RUN with count=0; busy=1 from the next cycle.
  - Signed ops (0, 2) capture magnitudes |rs|, |rt| as 32-bit unsigned; |0x80000000| is 0x80000000.
  - Record result sign = sign(rs)^sign(rt) and remainder sign = sign(rs).
  - op 6/7: no effect.
- RUN: one radix-2 step per edge, 32 edges; count wraps 31->0 and the state moves to FIX.
  - Multiply: shift-add on a 64-bit {acc,multiplier} register, LSB-first.
  - Divide: restoring division producing one quotient bit per step, 33-bit trial subtract.
- FIX: one edge.
  - Multiply: apply two's-complement negation to the 64-bit product if signed and the result sign is negative; hi<=product[63:32], lo<=product[31:0].
  - Divide: lo<=quotient, negated if signed and the result sign is negative; hi<=remainder, negated if signed and the remainder sign is negative. Quotient truncates toward zero.
  - Set done<=1 and state<=IDLE; busy falls at that edge.
- Latency: start accepted at edge E0 gives busy=1 for 33 cycles. Updated hi/lo and done=1 are visible after edge E33. done clears after E34.
- start while busy=1 is ignored entirely, including MTHI/MTLO; the decoder must stall.
- Divide by zero, defined as the natural restoring result on magnitudes:
  - DIVU x/0: lo=0xFFFFFFFF, hi=x.
  - DIV x/0: the quotient magnitude 0xFFFFFFFF is negated when sign(x) is negative (lo=0x00000001 for x<0, 0xFFFFFFFF for x>=0). hi=x.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- A new start in the done cycle is accepted, because busy=0 in that cycle.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the full 64-bit product combinationally at acceptance. The unit goes IDLE->FIX directly, so hi/lo and done appear after E1 and busy=1 for 1 cycle.
  - DIV/DIVU are unchanged.
- Undefined: all ops use the 32-step iterative path and 33-cycle busy as above.

Test Plan:
- Reset mid-RUN: start MULTU rs=5 rt=7, deassert rst_n at cycle 10 -> hi=0, lo=0, busy=0, done=0 immediately; no done pulse after reset release.
- MULT rs=0xFFFFFFFE (-2) rt=0x00000003 -> after 33 busy cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
  - With MULDIV_FAST_MULT_EN: same values, busy for 1 cycle.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU rs=7 rt=2 -> lo=3, hi=1.
- Divide edge cases:
  - DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xDEADBEEF then MTLO rs=0xCAFEF00D on consecutive cycles -> hi/lo updated one edge after each, busy never asserts, done stays 0.
- Issue MTLO rs=0x11111111 while busy from a DIVU -> ignored; final lo equals the quotient. A back-to-back start in the done cycle is accepted.
